// File: rtl/scratch_arb_pkg.sv
// ---------------------------------------------------------------------------
// scratch_arb_pkg
//   Shared constants and types for the scratch register bank arbiter.
//   NREG : number of scratch registers (power of two)
//   AW   : register index width, log2(NREG)
//   DW   : data word width; SW = DW/8 byte enables per word
//   arb_state_t : arbiter FSM states (IDLE, GRANT, DONE)
//   req_idx_t   : requester / owner index (0 = CPU bridge, 1 = debug port)
//   merge_bytes : byte-masked merge used by the single bank write port
// ---------------------------------------------------------------------------
package scratch_arb_pkg;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  // Replace only the bytes whose strobe bit is set; others keep old_w.
  function automatic logic [DW-1:0] merge_bytes(
    input logic [DW-1:0] old_w,
    input logic [DW-1:0] new_w,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/scratch_regfile.sv
// ---------------------------------------------------------------------------
// scratch_regfile
//   NREG x DW register bank with a single byte-masked write port, one
//   asynchronous read port, and all words exported flat in parallel.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears every word
//   we        : write enable (reset dominates, so nothing commits on a
//               reset edge)
//   waddr     : write word index
//   wdata     : write data
//   wstrb     : byte enables for the write
//   raddr     : read word index
//   rdata     : bank[raddr], combinational from registered storage
//   bank_flat : word i occupies bits [i*DW +: DW]
// ---------------------------------------------------------------------------
import scratch_arb_pkg::*;

module scratch_regfile (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DW-1:0]        wdata,
  input  logic [SW-1:0]        wstrb,
  input  logic [AW-1:0]        raddr,
  output logic [DW-1:0]        rdata,
  output logic [NREG*DW-1:0]   bank_flat
);

  logic [DW-1:0] bank [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else if (we) begin
      bank[waddr] <= merge_bytes(bank[waddr], wdata, wstrb);
    end
  end

  assign rdata = bank[raddr];

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign bank_flat[g*DW +: DW] = bank[g];
  end

endmodule

// File: rtl/scratch_bank_arbiter.sv
// ---------------------------------------------------------------------------
// scratch_bank_arbiter
//   Two-requester round-robin arbiter in front of the eight scratch
//   registers. Each granted request performs exactly one single-word read
//   or byte-masked write, then pulses Done for one cycle.
//   SI_ClkIn / SI_Reset : clock and synchronous active-high reset
//   Rn_Req    : request, held until Done is seen
//   Rn_We     : 1 = write, 0 = read
//   Rn_Addr   : register index
//   Rn_WData  : write data
//   Rn_WStrb  : byte enables for writes
//   Rn_Gnt    : requester owns the bank (GRANT and DONE cycles)
//   Rn_Done   : one-cycle completion pulse
//   Rn_RData  : last read result of that requester (valid while Done)
//   IO_SCRATCH0..7 : live bank contents
//   All outputs are registered.
// ---------------------------------------------------------------------------
import scratch_arb_pkg::*;

module scratch_bank_arbiter (
  input  logic            SI_ClkIn,
  input  logic            SI_Reset,
  input  logic            R0_Req,
  input  logic            R0_We,
  input  logic [AW-1:0]   R0_Addr,
  input  logic [DW-1:0]   R0_WData,
  input  logic [SW-1:0]   R0_WStrb,
  input  logic            R1_Req,
  input  logic            R1_We,
  input  logic [AW-1:0]   R1_Addr,
  input  logic [DW-1:0]   R1_WData,
  input  logic [SW-1:0]   R1_WStrb,
  output logic            R0_Gnt,
  output logic            R0_Done,
  output logic [DW-1:0]   R0_RData,
  output logic            R1_Gnt,
  output logic            R1_Done,
  output logic [DW-1:0]   R1_RData,
  output logic [DW-1:0]   IO_SCRATCH0,
  output logic [DW-1:0]   IO_SCRATCH1,
  output logic [DW-1:0]   IO_SCRATCH2,
  output logic [DW-1:0]   IO_SCRATCH3,
  output logic [DW-1:0]   IO_SCRATCH4,
  output logic [DW-1:0]   IO_SCRATCH5,
  output logic [DW-1:0]   IO_SCRATCH6,
  output logic [DW-1:0]   IO_SCRATCH7
);

  arb_state_t          state;
  req_idx_t            owner;
  req_idx_t            prio;
  req_idx_t            pick;

  logic                owner_req;
  logic                cmd_we;
  logic [AW-1:0]       cmd_addr;
  logic [DW-1:0]       cmd_wdata;
  logic [SW-1:0]       cmd_wstrb;
  logic                commit;
  logic                bank_we;
  logic [DW-1:0]       bank_rdata;
  logic [NREG*DW-1:0]  bank_flat;

  // Owner's command path into the single bank port.
  always_comb begin
    owner_req = R0_Req;
    cmd_we    = R0_We;
    cmd_addr  = R0_Addr;
    cmd_wdata = R0_WData;
    cmd_wstrb = R0_WStrb;
    if (owner) begin
      owner_req = R1_Req;
      cmd_we    = R1_We;
      cmd_addr  = R1_Addr;
      cmd_wdata = R1_WData;
      cmd_wstrb = R1_WStrb;
    end
  end

  // Lone requester wins outright; on a tie the priority pointer decides.
  always_comb begin
    pick = 1'b0;
    if (R0_Req && R1_Req) pick = prio;
    else if (R1_Req)      pick = 1'b1;
  end

  // The access happens on the edge that ends GRANT, only if the owner
  // still holds its request; otherwise the transaction is abandoned.
  assign commit  = (state == GRANT) && owner_req;
  assign bank_we = commit && cmd_we;

  scratch_regfile u_regfile (
    .clk       (SI_ClkIn),
    .rst       (SI_Reset),
    .we        (bank_we),
    .waddr     (cmd_addr),
    .wdata     (cmd_wdata),
    .wstrb     (cmd_wstrb),
    .raddr     (cmd_addr),
    .rdata     (bank_rdata),
    .bank_flat (bank_flat)
  );

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= 1'b0;
      R0_Gnt   <= 1'b0;
      R1_Gnt   <= 1'b0;
      R0_Done  <= 1'b0;
      R1_Done  <= 1'b0;
      R0_RData <= '0;
      R1_RData <= '0;
    end else begin
      R0_Done <= 1'b0;
      R1_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (R0_Req || R1_Req) begin
            state  <= GRANT;
            owner  <= pick;
            R0_Gnt <= ~pick;
            R1_Gnt <= pick;
          end
        end
        GRANT: begin
          if (owner_req) begin
            state <= DONE;
            if (owner) R1_Done <= 1'b1;
            else       R0_Done <= 1'b1;
            if (!cmd_we) begin
              if (owner) R1_RData <= bank_rdata;
              else       R0_RData <= bank_rdata;
            end
          end else begin
            // Abort leaves the priority pointer where it was.
            state  <= IDLE;
            R0_Gnt <= 1'b0;
            R1_Gnt <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          prio   <= ~owner;
          R0_Gnt <= 1'b0;
          R1_Gnt <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          R0_Gnt <= 1'b0;
          R1_Gnt <= 1'b0;
        end
      endcase
    end
  end

  assign IO_SCRATCH0 = bank_flat[0*DW +: DW];
  assign IO_SCRATCH1 = bank_flat[1*DW +: DW];
  assign IO_SCRATCH2 = bank_flat[2*DW +: DW];
  assign IO_SCRATCH3 = bank_flat[3*DW +: DW];
  assign IO_SCRATCH4 = bank_flat[4*DW +: DW];
  assign IO_SCRATCH5 = bank_flat[5*DW +: DW];
  assign IO_SCRATCH6 = bank_flat[6*DW +: DW];
  assign IO_SCRATCH7 = bank_flat[7*DW +: DW];

endmodule

// File: doc/scratch_bank_arbiter.md
# scratch_bank_arbiter

Sequencing and arbitration controller for the eight 32-bit scratch registers exported on the DE2-115 top level. Two requesters share one register bank through a req/gnt/done handshake with round-robin fairness:
- Requester 0: the CPU-side bus bridge.
- Requester 1: the external debug/host port.

The bank contents drive the IO_SCRATCH0..7 outputs continuously. Each access is a single-word read or byte-masked write.

## Interface
- NREG, 8, number of scratch registers (fixed power of two)
- AW, 3, register address width (log2 NREG)
- DW, 32, data width; byte-enable width is DW/8
- SI_ClkIn  in  1  system clock, all logic on rising edge
- SI_Reset  in  1  synchronous, active-high reset
- R0_Req, R1_Req  in  1 each  transaction request; held until Done seen
- R0_We, R1_We  in  1 each  1 = write, 0 = read
- R0_Addr, R1_Addr  in  AW each  register index
- R0_WData, R1_WData  in  DW each  write data
- R0_WStrb, R1_WStrb  in  DW/8 each  byte enables (write only)
- R0_Gnt, R1_Gnt  out  1 each  requester owns the bank (GRANT and DONE states)
- R0_Done, R1_Done  out  1 each  one-cycle completion pulse
- R0_RData, R1_RData  out  DW each  read data, valid while Done high
- IO_SCRATCH0..IO_SCRATCH7  out  DW each  current bank contents

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner selected; command sampled at end of this cycle.
  - DONE: Done pulse; return to IDLE.
- IDLE → GRANT when any Req is high.
  - If only one Req is high, that requester becomes owner.
  - If both are high, the owner is the requester named by the priority pointer Prio.
- GRANT → DONE if the owner's Req is still high.
  - At that edge: a write updates bytes selected by WStrb at Addr; a read captures bank[Addr] into that requester's RData.
  - WStrb = 0 on a write: no bank change, Done still pulses.
- GRANT → IDLE (abort) if the owner dropped Req during GRANT. No bank change, no Done, Prio unchanged.
- DONE → IDLE unconditionally. Prio is set to the non-owner. Req in DONE is ignored.
- Command signals (We, Addr, WData, WStrb) must be stable from the Req rise through GRANT. Only values at the GRANT-ending edge matter.
- The non-owner's Gnt, Done and RData are unaffected. Its RData holds its last read value.
- IDLE with Req still high starts a new transaction. Registered requesters that clear Req on seeing Done therefore issue exactly one access per request.
- Reset values:
  - state = IDLE, Prio = 0 (CPU favoured first).
  - All Gnt and Done = 0; RData = 0.
  - All bank registers and IO_SCRATCH0..7 = 0.
- Reset mid-transaction aborts it. No write commits on the reset edge.

## Timing
- Cycle k: Req high in IDLE.
- k+1: Gnt high (GRANT).
- k+2: Gnt high, Done high, RData valid. A write is visible on IO_SCRATCHn in this cycle.
- k+3: IDLE.
- Latency Req→Done is 2 cycles. Maximum throughput is 1 access per 3 cycles.
- Under continuous contention, grants alternate R0, R1, R0, … Worst-case wait is 5 cycles.
- Gnt, Done, RData and IO_SCRATCH are all registered outputs. There is no combinational path from any input to any output.
- The bank has a single write port. Simultaneous writes are impossible by construction.

## Structure
- Package scratch_arb_pkg holds:
  - the state enum (IDLE, GRANT, DONE);
  - the owner/requester index type;
  - constants NREG, AW, DW.
- Sub-module scratch_regfile: NREG×DW bank with one byte-masked write port, one read port and flat parallel outputs for IO_SCRATCH.
- The arbiter FSM, Prio register and per-requester RData registers live in scratch_bank_arbiter.

## Test plan
- Reset, then R0 write: Addr 3, WData 0xDEADBEEF, WStrb 0xF.
  - Required: R0_Gnt at k+1; R0_Done at k+2; IO_SCRATCH3 = 0xDEADBEEF from k+2; all other IO_SCRATCH = 0.
- Byte mask: SCRATCH5 = 0x11223344, then R1 write 0xAABBCCDD with WStrb 0x5.
  - Required: IO_SCRATCH5 = 0x11BB33DD; a subsequent R1 read of Addr 5 returns 0x11BB33DD with R1_Done.
- Contention: both Req high in the same IDLE cycle right after reset, both held.
  - Required: R0 served first, then R1, then R0. Done pulses at k+2, k+5, k+8.
- Abort: R1 drops Req during GRANT.
  - Required: IDLE next cycle, no R1_Done, bank unchanged. Prio unchanged, so a later simultaneous request goes to the same favoured requester.
- Reset in GRANT of an R0 write to Addr 7.
  - Required: IO_SCRATCH7 stays 0; Gnt and Done both 0 the cycle after reset; state IDLE.
- Read of untouched register: R0 reads Addr 0 after reset.
  - Required: R0_RData = 0x00000000 with Done. R1_RData stays unchanged throughout.
